imm_narrower: RTL
=================

// Module: imm_narrower
// PURPOSE
//  Narrows 32-bit values into immediate fields for instruction encoding: 17-bit zero-extended
//  (sel=0) or 18-bit sign-extended (sel=1), with range check, optional saturation and overflow flag.
//  Inverse of the datapath's immediate extender: when out_ovf=0, extending out_imm with the same
//  sel returns in_data exactly. Sits between the value source and the instruction assembler;
//  valid/ready on both sides with a 2-entry output queue.
// PARAMETERS
//  DATA_W  32  input value width
//  UNS_W   17  unsigned field width (sel=0)
//  SGN_W   18  signed field width (sel=1); also out_imm width
//  CNT_W   16  overflow counter width
// PORTS
//  clk        in   1       clock; single clock domain
//  rst        in   1       reset; synchronous, active-high
//  in_valid   in   1       input word valid
//  in_ready   out  1       block can accept a word this cycle
//  in_data    in   DATA_W  value to narrow
//  in_sel     in   1       0: unsigned UNS_W field, 1: signed SGN_W field
//  in_sat     in   1       1: saturate on overflow, 0: truncate
//  out_valid  out  1       result at queue head valid
//  out_ready  in   1       consumer takes head this cycle
//  out_imm    out  SGN_W   narrowed field; sel=0 -> bit 17 always 0
//  out_sel    out  1       in_sel carried with the result
//  out_ovf    out  1       value did not fit the selected field
//  ovf_count  out  CNT_W   overflowing words accepted since reset/clear, saturating
//  clr_count  in   1       clear ovf_count
// BEHAVIOUR
//  Reset: queue empty; out_valid=0, out_imm=0, out_sel=0, out_ovf=0, ovf_count=0; in_ready=1 the
//   cycle after rst deasserts. rst mid-operation discards queued results without signalling.
//  Accept: in_valid & in_ready. Push: computed result written into 2-entry FIFO same edge.
//  Latency: accepted at edge N -> visible on out_* from edge N (out_valid=1 after N) if queue was empty.
//  Pop: out_valid & out_ready; head advances at that edge. Order strictly preserved.
//  in_ready = (occupancy < 2); registered/derived from occupancy only, no combinational path from
//   out_ready. Full queue: in_ready=0 even if out_ready=1 that cycle.
//  Simultaneous push+pop with occupancy 1: occupancy stays 1, new word becomes head next cycle.
//  out_* hold stable while out_valid=1 and out_ready=0.
//  Range check, sel=0: fit iff in_data[31:17]==0. out_imm={1'b0,in_data[16:0]}.
//   Overflow: sat=1 -> out_imm=18'h1FFFF; sat=0 -> truncated low 17 bits, bit17=0.
//  Range check, sel=1: fit iff in_data[31:17] all equal (all 0 or all 1). out_imm=in_data[17:0].
//   Overflow: sat=1 -> in_data[31]=0 gives 18'h1FFFF (+131071), =1 gives 18'h20000 (-131072);
//   sat=0 -> in_data[17:0].
//  out_ovf = !fit, reported regardless of in_sat.
//  ovf_count: +1 per accepted overflowing word, sticks at 2^CNT_W-1. clr_count -> 0; if clear and
//   overflowing accept in same cycle, count becomes 1. Rejected (in_ready=0) words never counted.
// TESTING
//  sel=0, in_data=32'h0001_FFFF -> out_imm=18'h1FFFF, ovf=0; 32'h0002_0000 sat=1 -> 18'h1FFFF, ovf=1.
//  sel=1, in_data=32'hFFFE_0000 -> out_imm=18'h20000, ovf=0; 32'h0002_0000 sat=0 -> 18'h20000, ovf=1,
//   sat=1 -> 18'h1FFFF; 32'h8000_0000 sat=1 -> 18'h20000, ovf=1.
//  out_ready=0, push 3 words back-to-back -> in_ready drops after 2nd; 3rd held; release ->
//   outputs in order, one per cycle, in_ready returns the cycle after first pop.
//  Continuous in_valid/out_ready=1 with 100 random words -> throughput 1/cycle, every non-ovf
//   result extends back to in_data (zero-ext 17 / sign-ext 18).
//  5 overflowing words, clr_count with 6th -> ovf_count 1..5 then 1; force count to max -> holds.
//  rst asserted with 2 queued results -> next cycle out_valid=0, ovf_count=0, in_ready=1.

Source files
------------

// File: rtl/imm_narrower.sv
// Narrows 32-bit values into 17-bit unsigned / 18-bit signed immediate fields with
// range check, optional saturation, overflow flag/counter and a 2-entry output queue.
module imm_narrower #(
  parameter int DATA_W = 32,
  parameter int UNS_W  = 17,
  parameter int SGN_W  = 18,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SGN_W-1:0]  out_imm,
  output logic              out_sel,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  ovf_count,
  input  logic              clr_count
);

  localparam int HI_U = DATA_W - UNS_W;
  localparam int HI_S = DATA_W - SGN_W + 1;
  localparam logic [SGN_W-1:0] U_MAX = {{(SGN_W-UNS_W){1'b0}}, {UNS_W{1'b1}}};
  localparam logic [SGN_W-1:0] S_MAX = {1'b0, {(SGN_W-1){1'b1}}};
  localparam logic [SGN_W-1:0] S_MIN = {1'b1, {(SGN_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic             sel;
    logic             ovf;
    logic [SGN_W-1:0] imm;
  } entry_t;

  // Returns {overflow, field}; a value fits when every bit above the field agrees
  // with what the extender would regenerate (zeros, or copies of the sign bit).
  function automatic logic [SGN_W:0] narrow(input logic [DATA_W-1:0] d,
                                            input logic sel,
                                            input logic sat);
    logic             fit;
    logic [SGN_W-1:0] imm;
    if (sel) begin
      fit = (&d[DATA_W-1:SGN_W-1]) | ~(|d[DATA_W-1:SGN_W-1]);
      if (fit || !sat) begin
        imm = d[SGN_W-1:0];
      end else if (d[DATA_W-1]) begin
        imm = S_MIN;
      end else begin
        imm = S_MAX;
      end
    end else begin
      fit = (d[DATA_W-1:UNS_W] == {HI_U{1'b0}});
      if (fit || !sat) begin
        imm = {{(SGN_W-UNS_W){1'b0}}, d[UNS_W-1:0]};
      end else begin
        imm = U_MAX;
      end
    end
    return {~fit, imm};
  endfunction

  logic [1:0]     r_occ;
  logic           r_in_ready;
  logic           r_out_valid;
  entry_t         r_head;
  entry_t         r_tail;
  logic [CNT_W-1:0] r_cnt;

  logic [SGN_W:0] w_nar;
  entry_t         w_new;
  logic           w_push;
  logic           w_pop;
  logic [1:0]     w_occ_nxt;
  entry_t         w_head_nxt;
  entry_t         w_tail_nxt;
  logic           w_cnt_inc;

  assign w_nar     = narrow(in_data, in_sel, in_sat);
  assign w_new     = '{sel: in_sel, ovf: w_nar[SGN_W], imm: w_nar[SGN_W-1:0]};
  assign w_push    = in_valid & r_in_ready;
  assign w_pop     = r_out_valid & out_ready;
  assign w_cnt_inc = w_push & w_new.ovf;

  // Queue next-state: head register drives the outputs directly, tail holds the second word.
  always_comb begin
    w_occ_nxt  = r_occ;
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    case (r_occ)
      2'd0: begin
        if (w_push) begin
          w_head_nxt = w_new;
          w_occ_nxt  = 2'd1;
        end else begin
          w_occ_nxt  = 2'd0;
        end
      end
      2'd1: begin
        if (w_push && w_pop) begin
          w_head_nxt = w_new;
        end else if (w_push) begin
          w_tail_nxt = w_new;
          w_occ_nxt  = 2'd2;
        end else if (w_pop) begin
          w_occ_nxt  = 2'd0;
        end else begin
          w_occ_nxt  = 2'd1;
        end
      end
      2'd2: begin
        if (w_pop) begin
          w_head_nxt = r_tail;
          w_occ_nxt  = 2'd1;
        end else begin
          w_occ_nxt  = 2'd2;
        end
      end
      default: begin
        w_occ_nxt = 2'd0;
      end
    endcase
  end

  // Queue state; ready/valid are registered from the next occupancy so neither
  // depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ       <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head      <= '0;
      r_tail      <= '0;
    end else begin
      r_occ       <= w_occ_nxt;
      r_in_ready  <= (w_occ_nxt != 2'd2);
      r_out_valid <= (w_occ_nxt != 2'd0);
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
    end
  end

  // Saturating overflow counter; a clear coinciding with an overflowing accept leaves 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (clr_count) begin
      r_cnt <= w_cnt_inc ? CNT_ONE : {CNT_W{1'b0}};
    end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_imm   = r_head.imm;
  assign out_sel   = r_head.sel;
  assign out_ovf   = r_head.ovf;
  assign ovf_count = r_cnt;

endmodule
